// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and constants for the Z80 bus-cycle controller
package z80_bus_pkg;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_M1,
    CYC_MEM,
    CYC_IO,
    CYC_INTA
  } cyc_class_e;

  localparam int WAIT_CNT_W = 4;

  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int M1 = 0;

  function automatic cyc_class_e classify(
    input logic m1_cycle,
    input logic intcycle_n,
    input logic no_read,
    input logic write,
    input logic iorq
  );
    cyc_class_e c;
    c = CYC_NONE;
    if (m1_cycle) begin
      c = intcycle_n ? CYC_M1 : CYC_INTA;
    end else if (write || !no_read) begin
      c = iorq ? CYC_IO : CYC_MEM;
    end
    return c;
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// rtl/z80_wait_gen.sv - per-cycle-class internal wait-state counter merged with external wait_n
module z80_wait_gen
  import z80_bus_pkg::*;
#(
  parameter int M1_WAIT   = 0,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int INTA_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  cyc_class_e cyc,
  input  logic [6:0] ts,
  input  logic       wait_n,
  output logic       core_wait_n,
  output logic       wait_busy
);

  logic [WAIT_CNT_W-1:0] cnt;
  logic [WAIT_CNT_W-1:0] load_val;
  logic                  unused_ts;

  assign unused_ts = ^{ts[6:3], ts[0]};

  always_comb begin
    load_val = '0;
    case (cyc)
      CYC_M1:   load_val = WAIT_CNT_W'(M1_WAIT);
      CYC_MEM:  load_val = WAIT_CNT_W'(MEM_WAIT);
      CYC_IO:   load_val = WAIT_CNT_W'(IO_WAIT);
      CYC_INTA: load_val = WAIT_CNT_W'(INTA_WAIT);
      default:  load_val = '0;
    endcase
  end

  // T1 always reloads, so a cycle the core abandoned cannot leak waits into the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cen) begin
      if (ts[T1]) begin
        cnt <= load_val;
      end else if (ts[T2] && (cnt != '0)) begin
        cnt <= cnt - WAIT_CNT_W'(1);
      end
    end
  end

  // Internal count runs down while wait_n is low too, so the two waits overlap.
  assign core_wait_n = wait_n & (cnt == '0);
  assign wait_busy   = (cnt != '0);

endmodule

// File: rtl/z80_bus_ctrl.sv
// rtl/z80_bus_ctrl.sv - T80 bus-cycle controller: registered strobes, wait states, read-data latch
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter bit T2_WRITE  = 1'b1,
  parameter bit REFRESH   = 1'b0,
  parameter int M1_WAIT   = 0,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int INTA_WAIT = 2,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cen,
  input  logic [6:0]    mc,
  input  logic [6:0]    ts,
  input  logic          intcycle_n,
  input  logic          no_read,
  input  logic          write,
  input  logic          iorq,
  input  logic          wait_n,
  input  logic [DW-1:0] di,
  output logic          core_wait_n,
  output logic [DW-1:0] di_reg,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          wait_busy
);

  cyc_class_e cyc;
  logic       hold_w;
  logic       mreq_d, iorq_d, rd_d, wr_d;
  logic       wr_fire;
  logic       unused_in;

  assign unused_in = ^{mc[6:1], ts[6:4], ts[0]};

  assign cyc = classify(mc[M1], intcycle_n, no_read, write, iorq);

  z80_wait_gen #(
    .M1_WAIT   (M1_WAIT),
    .MEM_WAIT  (MEM_WAIT),
    .IO_WAIT   (IO_WAIT),
    .INTA_WAIT (INTA_WAIT)
  ) u_wait_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .cen         (cen),
    .cyc         (cyc),
    .ts          (ts),
    .wait_n      (wait_n),
    .core_wait_n (core_wait_n),
    .wait_busy   (wait_busy)
  );

  // Strobes stay asserted through T1 and every T2 that is being held by a wait.
  assign hold_w  = ts[T1] | (ts[T2] & ~core_wait_n);
  assign wr_fire = T2_WRITE ? hold_w : ts[T2];

  always_comb begin
    mreq_d = 1'b1;
    iorq_d = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    if (mc[M1]) begin
      if (hold_w) begin
        rd_d   = ~intcycle_n;
        mreq_d = ~intcycle_n;
        iorq_d = intcycle_n;
      end
      if (REFRESH && ts[T3]) begin
        mreq_d = 1'b0;
      end
    end else if (write) begin
      if (wr_fire) begin
        wr_d   = 1'b0;
        iorq_d = ~iorq;
        mreq_d = iorq;
      end
    end else if (!no_read && hold_w) begin
      rd_d   = 1'b0;
      iorq_d = ~iorq;
      mreq_d = iorq;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mreq_n <= 1'b1;
      iorq_n <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
    end else if (cen) begin
      mreq_n <= mreq_d;
      iorq_n <= iorq_d;
      rd_n   <= rd_d;
      wr_n   <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      di_reg <= '0;
    end else if (cen && ts[T2] && core_wait_n) begin
      di_reg <= di;
    end
  end

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// tb/tb_z80_bus_ctrl.sv - scoreboard bench for z80_bus_ctrl with a transaction-level bus-cycle model
module tb_z80_bus_ctrl;

  localparam int K_M1 = 0, K_INTA = 1, K_MRD = 2, K_MWR = 3, K_IRD = 4, K_IWR = 5, K_NONE = 6;
  localparam logic [6:0] TS1 = 7'b0000010, TS2 = 7'b0000100, TS3 = 7'b0001000, TS4 = 7'b0010000;

  typedef struct {
    int         d;
    int         step;
    logic [5:0] sig;
    logic [7:0] dv;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cen [2];
  logic [6:0] mc [2];
  logic [6:0] ts [2];
  logic       intcycle_n [2];
  logic       no_read [2];
  logic       write [2];
  logic       iorq [2];
  logic       wait_n [2];
  logic [7:0] di [2];
  logic       core_wait_n [2];
  logic [7:0] di_reg [2];
  logic       mreq_n [2];
  logic       iorq_n [2];
  logic       rd_n [2];
  logic       wr_n [2];
  logic       wait_busy [2];

  int total = 0;
  int bad = 0;
  int step = 0;
  exp_t q[$];

  logic [3:0] c_act [2];
  int         c_cnt [2];
  logic [7:0] c_di [2];

  always #5 clk = ~clk;

  z80_bus_ctrl #(
    .T2_WRITE(1'b0), .REFRESH(1'b0), .M1_WAIT(0), .MEM_WAIT(0), .IO_WAIT(3), .INTA_WAIT(2), .DW(8)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .cen(cen[0]), .mc(mc[0]), .ts(ts[0]), .intcycle_n(intcycle_n[0]),
    .no_read(no_read[0]), .write(write[0]), .iorq(iorq[0]), .wait_n(wait_n[0]), .di(di[0]),
    .core_wait_n(core_wait_n[0]), .di_reg(di_reg[0]), .mreq_n(mreq_n[0]), .iorq_n(iorq_n[0]),
    .rd_n(rd_n[0]), .wr_n(wr_n[0]), .wait_busy(wait_busy[0])
  );

  z80_bus_ctrl #(
    .T2_WRITE(1'b1), .REFRESH(1'b1), .M1_WAIT(1), .MEM_WAIT(0), .IO_WAIT(2), .INTA_WAIT(1), .DW(8)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .cen(cen[1]), .mc(mc[1]), .ts(ts[1]), .intcycle_n(intcycle_n[1]),
    .no_read(no_read[1]), .write(write[1]), .iorq(iorq[1]), .wait_n(wait_n[1]), .di(di[1]),
    .core_wait_n(core_wait_n[1]), .di_reg(di_reg[1]), .mreq_n(mreq_n[1]), .iorq_n(iorq_n[1]),
    .rd_n(rd_n[1]), .wr_n(wr_n[1]), .wait_busy(wait_busy[1])
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
  endtask

  function automatic int nwait(input int d, input int k);
    case (k)
      K_M1:         return (d == 0) ? 0 : 1;
      K_INTA:       return (d == 0) ? 2 : 1;
      K_IRD, K_IWR: return (d == 0) ? 3 : 2;
      default:      return 0;
    endcase
  endfunction

  // Strobes asserted ({mreq,iorq,rd,wr}) by the enabled edge at position p of an access
  // whose T2 lasts L clocks: position 0 is T1, 1..L are T2, L+1 is T3, L+2 is T4.
  function automatic logic [3:0] eff_act(input int d, input int k, input int p, input int l);
    logic main, refr, wsel;
    main = (p <= l - 1);
    refr = (d == 1) && (p == l + 1);
    wsel = (d == 1) ? main : ((p >= 1) && (p <= l));
    case (k)
      K_M1:    return {main | refr, 1'b0, main, 1'b0};
      K_INTA:  return {refr, main, 1'b0, 1'b0};
      K_MRD:   return {main, 1'b0, main, 1'b0};
      K_IRD:   return {1'b0, main, main, 1'b0};
      K_MWR:   return {wsel, 1'b0, 1'b0, wsel};
      K_IWR:   return {1'b0, wsel, 1'b0, wsel};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int eff_cnt(input int n, input int p, input int l);
    if (p == 0) return n;
    if (p <= l) return (n > p) ? n - p : 0;
    return 0;
  endfunction

  task automatic push(input int d, input logic [3:0] act, input int cnt, input logic wn);
    exp_t e;
    e.d = d;
    e.step = step;
    e.sig = {~act, wn & (cnt == 0), cnt != 0};
    e.dv = c_di[d];
    q.push_back(e);
  endtask

  // e = external wait clocks at the start of T2; abort_at >= 0 ends the access early.
  task automatic do_xact(input int d, input int k, input int e, input int abort_at,
                         input bit force_di, input bit stall_all);
    int n, l, last, nst, vcnt;
    logic [3:0] vact;
    logic wn;
    n = nwait(d, k);
    l = ((n > e) ? n : e) + 1;
    last = (abort_at >= 0) ? abort_at : (((k == K_M1) || (k == K_INTA)) ? l + 2 : l + 1);
    intcycle_n[d] = (k != K_INTA);
    mc[d] = ((k == K_M1) || (k == K_INTA)) ? 7'b0000001 : (7'b0000001 << $urandom_range(1, 6));
    write[d] = (k == K_MWR) || (k == K_IWR);
    iorq[d] = (k == K_IRD) || (k == K_IWR) || ((k == K_NONE) && ($urandom_range(0, 1) == 1));
    no_read[d] = (k == K_NONE) || (write[d] && ($urandom_range(0, 1) == 1));
    for (int p = 0; p <= last; p++) begin
      ts[d] = (p == 0) ? TS1 : (p <= l) ? TS2 : (p == l + 1) ? TS3 : TS4;
      vact = (p == 0) ? c_act[d] : eff_act(d, k, p - 1, l);
      vcnt = (p == 0) ? c_cnt[d] : eff_cnt(n, p - 1, l);
      wn = ((p >= 1) && (p <= l)) ? (p > e) : 1'($urandom_range(0, 1));
      nst = stall_all ? 1 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      for (int s = 0; s < nst; s++) begin
        cen[d] = 1'b0;
        wait_n[d] = 1'($urandom_range(0, 1));
        di[d] = 8'($urandom);
        push(d, vact, vcnt, wait_n[d]);
        tick();
      end
      cen[d] = 1'b1;
      wait_n[d] = wn;
      di[d] = (force_di && (p == l)) ? 8'hA5 : 8'($urandom);
      push(d, vact, vcnt, wn);
      tick();
      if (p == l) c_di[d] = di[d];
    end
    c_act[d] = eff_act(d, k, last, l);
    c_cnt[d] = eff_cnt(n, last, l);
    cen[d] = 1'b0;
  endtask

  task automatic random_run(input int d, input int count);
    int k, e, ab, n;
    for (int i = 0; i < count; i++) begin
      k = $urandom_range(0, 6);
      e = $urandom_range(0, 4);
      n = nwait(d, k);
      ab = ((n >= 2) && ($urandom_range(0, 4) == 0)) ? $urandom_range(1, n - 1) : -1;
      do_xact(d, k, e, ab, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_mid_read();
    cen[0] = 1'b1;
    mc[0] = 7'b0000010;
    ts[0] = TS1;
    intcycle_n[0] = 1'b1;
    no_read[0] = 1'b0;
    write[0] = 1'b0;
    iorq[0] = 1'b1;
    wait_n[0] = 1'b1;
    tick();
    chk("rst pre rd_n", 16'(rd_n[0]), 16'h0);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst strobes d%0d", d), 16'({mreq_n[d], iorq_n[d], rd_n[d], wr_n[d]}), 16'hF);
      chk($sformatf("rst di_reg d%0d", d), 16'(di_reg[d]), 16'h0);
    end
    ts[0] = 7'b0;
    cen[0] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      c_act[d] = 4'b0;
      c_cnt[d] = 0;
      c_di[d] = 8'h00;
      wait_n[d] = 1'b0;
      #1 chk($sformatf("rst cwn0 d%0d", d), 16'(core_wait_n[d]), 16'h0);
      wait_n[d] = 1'b1;
      #1 chk($sformatf("rst cwn1 d%0d", d), 16'(core_wait_n[d]), 16'h1);
    end
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("bus d%0d s%0d", e.d, e.step),
            {10'd0, mreq_n[e.d], iorq_n[e.d], rd_n[e.d], wr_n[e.d], core_wait_n[e.d], wait_busy[e.d]},
            {10'd0, e.sig});
        chk($sformatf("di_reg d%0d s%0d", e.d, e.step), {8'd0, di_reg[e.d]}, {8'd0, e.dv});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int d = 0; d < 2; d++) begin
      cen[d] = 1'b0;
      mc[d] = 7'b0;
      ts[d] = 7'b0;
      intcycle_n[d] = 1'b1;
      no_read[d] = 1'b1;
      write[d] = 1'b0;
      iorq[d] = 1'b0;
      wait_n[d] = 1'b1;
      di[d] = 8'h00;
      c_act[d] = 4'b0;
      c_cnt[d] = 0;
      c_di[d] = 8'h00;
    end
    #7;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset strobes d%0d", d), 16'({mreq_n[d], iorq_n[d], rd_n[d], wr_n[d], wait_busy[d]}), 16'h1E);
      chk($sformatf("reset di_reg d%0d", d), 16'(di_reg[d]), 16'h0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_n[0] = 1'b0;
    #1 chk("reset cwn follows", 16'(core_wait_n[0]), 16'h0);
    wait_n[0] = 1'b1;
    tick();

    do_xact(0, K_M1, 0, -1, 1'b1, 1'b0);
    do_xact(0, K_IRD, 0, -1, 1'b0, 1'b0);
    do_xact(0, K_MWR, 0, -1, 1'b0, 1'b0);
    do_xact(1, K_MWR, 0, -1, 1'b0, 1'b0);
    do_xact(0, K_INTA, 4, -1, 1'b0, 1'b0);
    do_xact(1, K_M1, 0, -1, 1'b0, 1'b1);
    do_xact(0, K_IWR, 0, 1, 1'b0, 1'b0);
    do_xact(0, K_MRD, 2, -1, 1'b0, 1'b0);
    reset_mid_read();
    random_run(0, 40);
    random_run(1, 40);
    do_xact(1, K_INTA, 3, -1, 1'b0, 1'b1);

    repeat (3) tick();
    if (q.size() != 0) chk("drain", 16'(q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
